// File: rtl/alu_pkg.sv
// Shared opcode, flag and state definitions for the registered ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the register file side and the ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [2:0]       fun;
    logic [WIDTH-1:0] Rx;
    logic [WIDTH-1:0] Ry;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic [2:0]       band;

    modport master (
        output start, fun, Rx, Ry,
        input  busy, done, Result, band
    );

    modport slave (
        input  start, fun, Rx, Ry,
        output busy, done, Result, band
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per step.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic               last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    // prod is the accumulator after the current step, so the
    // caller can write back on the same edge as the final step.
    assign prod = acc + (mplier[0] ? mcand : '0);
    assign last = step && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (step) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake and
// a multi-cycle multiply path.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0]   result_q;
    logic [2:0]         band_q;
    logic               done_q;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_c;

    logic               mul_load;
    logic               mul_step;
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_last;

    logic               wr;
    logic [WIDTH-1:0]   res_d;
    logic               c_d;

    assign sum  = {1'b0, bus.Rx} + {1'b0, bus.Ry};
    assign diff = {1'b0, bus.Rx} - {1'b0, bus.Ry};

    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        unique case (1'b1)
            (bus.fun == OP_ADD): begin
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
            end
            (bus.fun == OP_SUB): begin
                sc_res = diff[WIDTH-1:0];
                sc_c   = diff[WIDTH];
            end
            (bus.fun == OP_AND): sc_res = bus.Rx & bus.Ry;
            (bus.fun == OP_OR):  sc_res = bus.Rx | bus.Ry;
            (bus.fun == OP_XOR): sc_res = bus.Rx ^ bus.Ry;
            (bus.fun == OP_NOT): sc_res = ~bus.Rx;
            (bus.fun == OP_SHR): begin
                // Oversized shifts give an all-ones mask: every bit lost.
                sc_res = bus.Rx >> bus.Ry;
                sc_c   = |(bus.Rx & ~({WIDTH{1'b1}} << bus.Ry));
            end
            default: begin
                sc_res = '0;
                sc_c   = 1'b0;
            end
        endcase
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk  (clk),
        .rst  (rst),
        .load (mul_load),
        .step (mul_step),
        .a    (bus.Rx),
        .b    (bus.Ry),
        .prod (mul_prod),
        .last (mul_last)
    );

    always_comb begin
        state_nx = state;
        mul_load = 1'b0;
        mul_step = 1'b0;
        wr       = 1'b0;
        res_d    = '0;
        c_d      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.fun == OP_MUL) begin
                        mul_load = 1'b1;
                        state_nx = ST_MUL;
                    end else begin
                        wr    = 1'b1;
                        res_d = sc_res;
                        c_d   = sc_c;
                    end
                end
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    wr       = 1'b1;
                    res_d    = mul_prod[WIDTH-1:0];
                    c_d      = |mul_prod[2*WIDTH-1:WIDTH];
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            band_q   <= '0;
        end else begin
            state  <= state_nx;
            done_q <= wr;
            if (wr) begin
                result_q       <= res_d;
                band_q[FLAG_N] <= res_d[WIDTH-1];
                band_q[FLAG_C] <= c_d;
                band_q[FLAG_Z] <= (res_d == '0);
            end
        end
    end

    assign bus.busy   = (state == ST_MUL);
    assign bus.done   = done_q;
    assign bus.Result = result_q;
    assign bus.band   = band_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Same 3-bit opcode field, Rx/Ry operands, Result and 3-bit flag output `band`.
- Adds a start/busy/done handshake, operand capture, and a multi-cycle shift-add multiply.
- Sits between the register file and the writeback stage of the microprocessor datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; accepted only when busy=0
- fun  in  3  opcode, sampled with start
- Rx  in  WIDTH  operand A, sampled with start
- Ry  in  WIDTH  operand B, sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; Result/band valid
- Result  out  WIDTH  registered result
- band  out  3  registered flags: [2]=N (Result MSB), [1]=C (carry/borrow/overflow), [0]=Z (Result==0)

Behaviour:
- One clock (clk); reset is synchronous and active-high on rst.
- Reset: busy=0, done=0, Result=0, band=0, FSM returns to IDLE.
- Reset wins over all other inputs, including mid-operation; any in-flight multiply is aborted with no done pulse.
- FSM states are IDLE and MUL.
  - IDLE + start: capture fun/Rx/Ry on edge k.
  - Non-MUL opcode: Result/band update and done=1 after edge k (latency 1); busy stays 0; FSM remains in IDLE.
  - fun=110: go to MUL with busy=1.
  - MUL: one shift-add iteration per edge; after edge k+WIDTH write Result/band, done=1, busy=0, return to IDLE.
- start while busy=1 is ignored and not queued. Operand/fun changes during busy have no effect.
- done is a single-cycle pulse. A new single-cycle op can be accepted on the cycle done is high if busy=0, so back-to-back single-cycle ops give done on consecutive cycles.
- Result and band hold their last values until the next done; they never change while busy.
- Opcodes (all arithmetic modulo 2^WIDTH):
  - 000 ADD: Rx+Ry; C=carry-out.
  - 001 SUB: Rx-Ry; C=borrow (Rx<Ry unsigned).
  - 010 AND, 011 OR, 100 XOR: C=0.
  - 101 NOT: ~Rx; Ry ignored; C=0.
  - 110 MUL: unsigned; Result=low WIDTH bits of the 2*WIDTH product; C=1 if the upper WIDTH bits are nonzero.
  - 111 SHR: logical Rx>>Ry.
    - Ry>=WIDTH gives Result=0.
    - C = OR of all bits shifted out; C=0 when Ry=0.
- N and Z are always derived from the final Result.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_SHR (3 bits);
  - flag bit indices FLAG_N=2, FLAG_C=1, FLAG_Z=0;
  - FSM state encoding ST_IDLE, ST_MUL.
- One sub-module, alu_mul_seq: shift-add multiplier with load/step/count interface. It holds a 2*WIDTH accumulator, a shifted multiplier, and a counter of width clog2(WIDTH+1). It asserts its last-step flag on iteration WIDTH.
- The top level holds the opcode decode, single-cycle datapath, flag generation and FSM.

Test Plan (WIDTH=8):
- ADD/SUB: start fun=000 Rx=0x01 Ry=0xFF -> next cycle done=1, Result=0x00, band=3'b011. Then fun=001, same operands -> Result=0x02, band=3'b010.
- Logic sweep: Rx=0xF0, Ry=0x3C.
  - AND -> 0x30, band=000
  - OR -> 0xFC, band=100
  - XOR -> 0xCC, band=100
  - NOT -> 0x0F, band=000
  - All on consecutive cycles, one done pulse each.
- MUL: start fun=110 Rx=0x10 Ry=0x11 at edge k.
  - busy=1 for 8 cycles; done only after edge k+8.
  - Result=0x10, band=3'b010.
  - A start with fun=000 at k+3 is ignored: no extra done, Result unchanged.
- SHR: Rx=0x81 Ry=0x01 -> 0x40, band=010. Rx=0x81 Ry=0x09 -> 0x00, band=011. Rx=0x81 Ry=0x00 -> 0x81, band=100.
- Reset mid-MUL: start MUL Rx=0xFF Ry=0xFF, assert rst on edge k+4.
  - Next cycle: busy=0, done=0, Result=0, band=0; no later done.
  - A fresh MUL 0x0F*0x0F then gives Result=0xE1, band=3'b100 after 8 cycles.
- Hold check: after any done, with 20 idle cycles and random Rx/Ry/fun toggling without start, Result/band stay constant and done stays 0.
